// File: rtl/watch_uart_tx_report.sv
// Snapshots the watch time and transmits it as an ASCII line "HH:MM:SS\r\n" over 8N1 UART.
// Optional macro WATCH_TX_MSEC_EN inserts ".CC" (hundredths) after the seconds.
module watch_uart_tx_report #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
`ifdef WATCH_TX_MSEC_EN
  localparam int unsigned NBYTES = 13;
`else
  localparam int unsigned NBYTES = 10;
`endif
  localparam logic [3:0] LAST_BYTE = 4'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_FINISH
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_baud, w_baud_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [3:0]      r_byte_idx, w_byte_n;
  logic            r_tx, r_busy, r_done;
  logic            w_tx_n;
  logic            w_accept;
  logic [7:0]      w_char;
  logic [4:0]      r_snap_hour;
  logic [5:0]      r_snap_min;
  logic [5:0]      r_snap_sec;
`ifdef WATCH_TX_MSEC_EN
  logic [6:0]      r_snap_msec;
`else
  logic            w_unused_msec;
  assign w_unused_msec = ^msec;
`endif

  // Values above 99 can only come from msec; they saturate to "99".
  function automatic logic [7:0] f_tens(input logic [6:0] v);
    logic [6:0] c;
    c = (v > 7'd99) ? 7'd99 : v;
    return 8'h30 + 8'(c / 7'd10);
  endfunction

  function automatic logic [7:0] f_ones(input logic [6:0] v);
    logic [6:0] c;
    c = (v > 7'd99) ? 7'd99 : v;
    return 8'h30 + 8'(c % 7'd10);
  endfunction

  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_char = 8'h0A;
    case (r_byte_idx)
      4'd0:    w_char = f_tens({2'b00, r_snap_hour});
      4'd1:    w_char = f_ones({2'b00, r_snap_hour});
      4'd2:    w_char = 8'h3A;
      4'd3:    w_char = f_tens({1'b0, r_snap_min});
      4'd4:    w_char = f_ones({1'b0, r_snap_min});
      4'd5:    w_char = 8'h3A;
      4'd6:    w_char = f_tens({1'b0, r_snap_sec});
      4'd7:    w_char = f_ones({1'b0, r_snap_sec});
`ifdef WATCH_TX_MSEC_EN
      4'd8:    w_char = 8'h2E;
      4'd9:    w_char = f_tens(r_snap_msec);
      4'd10:   w_char = f_ones(r_snap_msec);
      4'd11:   w_char = 8'h0D;
`else
      4'd8:    w_char = 8'h0D;
`endif
      default: w_char = 8'h0A;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_byte_n  = r_byte_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_START;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_byte_n  = '0;
        end
      end
      S_START: begin
        if (r_baud == BAUD_LAST) begin
          w_state_n = S_DATA;
          w_baud_n  = '0;
          w_bit_n   = '0;
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) w_state_n = S_STOP;
          else               w_bit_n   = r_bit + 1'b1;
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n = '0;
          if (r_byte_idx == LAST_BYTE) begin
            w_state_n = S_FINISH;
          end else begin
            w_state_n = S_START;
            w_byte_n  = r_byte_idx + 1'b1;
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      S_FINISH: w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes exactly on bit boundaries.
  always_comb begin
    w_tx_n = 1'b1;
    case (w_state_n)
      S_START: w_tx_n = 1'b0;
      S_DATA:  w_tx_n = w_char[w_bit_n];
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_baud     <= w_baud_n;
      r_bit      <= w_bit_n;
      r_byte_idx <= w_byte_n;
      r_tx       <= w_tx_n;
      r_busy     <= (w_state_n == S_START) || (w_state_n == S_DATA) || (w_state_n == S_STOP);
      r_done     <= (w_state_n == S_FINISH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_hour <= '0;
      r_snap_min  <= '0;
      r_snap_sec  <= '0;
`ifdef WATCH_TX_MSEC_EN
      r_snap_msec <= '0;
`endif
    end else if (w_accept) begin
      r_snap_hour <= hour;
      r_snap_min  <= min;
      r_snap_sec  <= sec;
`ifdef WATCH_TX_MSEC_EN
      r_snap_msec <= msec;
`endif
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_watch_uart_tx_report.sv
// Directed bench for watch_uart_tx_report at BAUD_DIV=10; frame contents follow WATCH_TX_MSEC_EN.
module tb_watch_uart_tx_report;

`ifdef WATCH_TX_MSEC_EN
  localparam int NB = 13;
`else
  localparam int NB = 10;
`endif
  localparam int NCYC = NB * 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] msec = '0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hour = '0;
  logic       tx, busy, done;

  int n_pass = 0;
  int n_total = 0;

  watch_uart_tx_report #(.CLK_FREQ(100), .BAUD(10)) dut (
    .clk(clk), .rst(rst), .start(start), .msec(msec), .sec(sec),
    .min(min), .hour(hour), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a whole line cycle by cycle from the accepting edge to the done pulse.
  // pre=1: the start edge already happened. chg_k: cycle at which inputs are zeroed.
  // p1/p2: cycles with a mid-frame start pulse. chain: request a new line right after done.
  task automatic run_frame(input string name, input logic [4:0] h, input logic [5:0] m,
                           input logic [5:0] s, input logic [6:0] ms,
                           input string exp10, input string exp13, input bit pre,
                           input int chg_k, input int p1, input int p2, input bit chain);
    string      expl;
    logic [7:0] exp_b;
    logic [7:0] rx [NB];
    logic       exp_tx;
    int         p, b, j, errs;
    bit         early;
`ifdef WATCH_TX_MSEC_EN
    expl = {exp13, "\r\n"};
`else
    expl = {exp10, "\r\n"};
`endif
    if (!pre) begin
      hour = h; min = m; sec = s; msec = ms;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    errs = 0;
    early = 0;
    for (int k = 0; k < NCYC; k++) begin
      p = k / 10;
      b = p / 10;
      j = p % 10;
      exp_b = expl[b];
      exp_tx = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_b[j-1];
      if (tx !== exp_tx || busy !== 1'b1) errs++;
      if (done !== 1'b0) early = 1;
      if (j >= 1 && j <= 8 && (k % 10) == 5) rx[b][j-1] = tx;
      if (k == chg_k) begin
        hour = '0; min = '0; sec = '0; msec = '0;
      end
      start = (k == p1 || k == p2);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      exp_b = expl[i];
      n_total++;
      if (rx[i] !== exp_b) $display("FAIL %s byte%0d: got 0x%02h expected 0x%02h", name, i, rx[i], exp_b);
      else n_pass++;
    end
    n_total++;
    if (errs !== 0) $display("FAIL %s bit_timing: mismatched cycles %0d expected 0", name, errs);
    else n_pass++;
    n_total++;
    if (early !== 1'b0) $display("FAIL %s done_early: got %0d expected 0", name, early);
    else n_pass++;
    n_total++;
    if (done !== 1'b1) $display("FAIL %s done_at_latency: got %b expected 1", name, done);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL %s finish_state: busy=%b tx=%b expected busy=0 tx=1", name, busy, tx);
    else n_pass++;
    if (chain) begin
      start = 1'b1;
      tick();
      n_total++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL %s finish_start_ignored: tx=%b busy=%b done=%b expected 1 0 0", name, tx, busy, done);
      else n_pass++;
      tick();
      start = 1'b0;
      n_total++;
      if (tx !== 1'b0 || busy !== 1'b1)
        $display("FAIL %s start_after_done: tx=%b busy=%b expected 0 1", name, tx, busy);
      else n_pass++;
    end else begin
      tick();
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1)
        $display("FAIL %s post_done: done=%b busy=%b tx=%b expected 0 0 1", name, done, busy, tx);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_total++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
    else n_pass++;
    rst = 1'b0;
    repeat (20) tick();
    n_total++;
    if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL idle_line: tx=%b busy=%b expected 1 0", tx, busy);
    else n_pass++;
  endtask

  task automatic test_basic_frame();
    run_frame("basic", 5'd12, 6'd34, 6'd56, 7'd7, "12:34:56", "12:34:56.07", 0, -1, -1, -1, 0);
  endtask

  task automatic test_snapshot();
    run_frame("snapshot", 5'd23, 6'd59, 6'd59, 7'd99, "23:59:59", "23:59:59.99", 0, 250, -1, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_frame("busy_reject", 5'd7, 6'd8, 6'd9, 7'd10, "07:08:09", "07:08:09.10", 0, -1, 50, 500, 1);
    run_frame("after_done", 5'd7, 6'd8, 6'd9, 7'd10, "07:08:09", "07:08:09.10", 1, -1, -1, -1, 0);
  endtask

  task automatic test_reset_midframe();
    int bad;
    hour = 5'd5; min = 6'd6; sec = 6'd7; msec = 7'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midframe_reset: tx=%b busy=%b done=%b expected 1 0 0", tx, busy, done);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < NCYC + 200; k++) begin
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
      tick();
    end
    n_total++;
    if (bad !== 0) $display("FAIL aborted_frame_quiet: active cycles %0d expected 0", bad);
    else n_pass++;
    run_frame("after_reset", 5'd5, 6'd6, 6'd7, 7'd8, "05:06:07", "05:06:07.08", 0, -1, -1, -1, 0);
  endtask

  task automatic test_boundary();
    run_frame("zero_nine", 5'd0, 6'd0, 6'd9, 7'd0, "00:00:09", "00:00:09.00", 0, -1, -1, -1, 0);
    run_frame("out_of_range", 5'd31, 6'd0, 6'd63, 7'd99, "31:00:63", "31:00:63.99", 0, -1, -1, -1, 0);
  endtask

  task automatic test_msec();
    run_frame("msec_7", 5'd1, 6'd2, 6'd3, 7'd7, "01:02:03", "01:02:03.07", 0, -1, -1, -1, 0);
    run_frame("msec_clamp", 5'd1, 6'd2, 6'd3, 7'd120, "01:02:03", "01:02:03.99", 0, -1, -1, -1, 0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_snapshot();
    test_back_to_back();
    test_reset_midframe();
    test_boundary();
    test_msec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
